// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: state encodings, line levels and
// width helpers used by the transmitter and the bit timer.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Word handshake between upstream logic and the serial transmitter.
interface uart_tx_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_bit_timer.sv
// Free-running bit-period counter: ticks on the last cycle of each bit and
// wraps to zero, so every bit boundary restarts the count.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int TW = cnt_w(CLKS_PER_BIT);

  logic [TW-1:0] cnt;

  assign tick = (cnt == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB-first, stop bit,
// with one mandatory idle cycle between frames.
module uart_tx_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_serializer_if.slave  tx,
  output logic                 txd,
  output logic                 busy
);

  localparam int IW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             txd_q, txd_d;
  logic             tick, tmr_clr, accept, last_bit;

  // Timer held at zero in IDLE so the start bit gets a full period after accept.
  assign tmr_clr  = (state_q == IDLE);
  assign accept   = tx.tx_valid & tx.tx_ready;
  assign last_bit = (idx_q == IW'(WIDTH - 1));

  serial_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk   (clk),
    .rst_n (reset),
    .clr   (tmr_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = START;
        shift_d = tx.tx_data;
      end
      START: if (tick) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (tick) begin
        if (last_bit) state_d = STOP;
        else begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
        end
      end
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line level is computed from the next state so txd can be registered
  // without adding a cycle of latency.
  always_comb begin
    tx.tx_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    unique case (state_d)
      START:   txd_d = START_BIT;
      DATA:    txd_d = shift_d[0];
      STOP:    txd_d = STOP_BIT;
      default: txd_d = LINE_IDLE;
    endcase
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomised scoreboard bench: one transmitter at 4 clocks/bit, one at 1.
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  logic rst_n;
  logic txd_a, busy_a, txd_b, busy_b;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  logic [7:0] expq_a[$];
  logic [7:0] expq_b[$];
  int         starts_a[$];
  bit         act_a = 0, act_b = 0;

  uart_tx_serializer_if #(.WIDTH(8)) ifa ();
  uart_tx_serializer_if #(.WIDTH(8)) ifb ();

  uart_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(4)) ua (
    .clk(clk), .reset(rst_n), .tx(ifa), .txd(txd_a), .busy(busy_a));
  uart_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(1)) ub (
    .clk(clk), .reset(rst_n), .tx(ifb), .txd(txd_b), .busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic get_txd(input int id);  return (id == 0) ? txd_a : txd_b;  endfunction
  function automatic logic get_busy(input int id); return (id == 0) ? busy_a : busy_b; endfunction
  function automatic logic get_rdy(input int id);  return (id == 0) ? ifa.tx_ready : ifb.tx_ready; endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: sample k of the line belongs to bit k/cpb of {stop, word, start}.
  function automatic logic [63:0] ref_frame(input logic [7:0] w, input int cpb);
    logic [9:0]  bits;
    logic [63:0] f;
    bits = {1'b1, w, 1'b0};
    f = '0;
    for (int k = 0; k < 10 * cpb; k++) f[k] = bits[k / cpb];
    return f;
  endfunction

  task automatic mon(input int id, input int cpb);
    logic [63:0] act;
    logic [7:0]  w;
    bit          bz_ok, post_ok, aborted;
    int          n;
    n = 10 * cpb;
    forever begin
      @(negedge clk);
      if (!rst_n || get_txd(id) !== 1'b0) continue;
      if (id == 0) begin act_a = 1; starts_a.push_back(cyc); end else act_b = 1;
      act = '0;
      bz_ok = get_busy(id) && !get_rdy(id);
      aborted = 0;
      for (int k = 1; k < n; k++) begin
        @(negedge clk);
        if (!rst_n) begin aborted = 1; break; end
        act[k] = get_txd(id);
        bz_ok &= get_busy(id) && !get_rdy(id);
      end
      if (!aborted) begin
        @(negedge clk);
        post_ok = !get_busy(id) && get_rdy(id) && get_txd(id);
        if ((id == 0 ? expq_a.size() : expq_b.size()) == 0) begin
          chk(0, id == 0 ? "unexpected_frame_a" : "unexpected_frame_b", act, 0);
        end else begin
          w = (id == 0) ? expq_a.pop_front() : expq_b.pop_front();
          chk(act == ref_frame(w, cpb), id == 0 ? "frame_a" : "frame_b", act, ref_frame(w, cpb));
          chk(bz_ok, "busy_during_frame", {63'd0, bz_ok}, 1);
          chk(post_ok, "idle_after_frame", {63'd0, post_ok}, 1);
        end
      end
      if (id == 0) act_a = 0; else act_b = 0;
    end
  endtask

  initial mon(0, 4);
  initial mon(1, 1);

  task automatic set_in(input int id, input logic v, input logic [7:0] d);
    if (id == 0) begin ifa.tx_valid = v; ifa.tx_data = d; end
    else         begin ifb.tx_valid = v; ifb.tx_data = d; end
  endtask

  task automatic send(input int id, input logic [7:0] w, input bit hold);
    int n;
    n = 0;
    set_in(id, 1'b1, w);
    while (!get_rdy(id) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      chk(0, "send_ready_timeout", 0, 1);
      set_in(id, 1'b0, w);
      return;
    end
    if (id == 0) expq_a.push_back(w); else expq_b.push_back(w);
    @(posedge clk); #1;
    if (!hold) set_in(id, 1'b0, w);
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (id == 0 && expq_a.size() == 0 && !act_a && ifa.tx_ready) break;
      if (id == 1 && expq_b.size() == 0 && !act_b && ifb.tx_ready) break;
      n++;
    end
    if (n >= 2000) chk(0, "wait_idle_timeout", id, 0);
  endtask

  initial begin
    int s0;
    rst_n = 1'b0;
    set_in(0, 1'b1, 8'h77);   // valid during reset must be ignored
    set_in(1, 1'b1, 8'h77);
    repeat (2) @(posedge clk);
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    #3 rst_n = 1'b1;

    // Reset and idle
    repeat (6) begin
      @(negedge clk);
      chk({txd_a, ifa.tx_ready, busy_a} == 3'b110, "idle_a", {txd_a, ifa.tx_ready, busy_a}, 3'b110);
      chk({txd_b, ifb.tx_ready, busy_b} == 3'b110, "idle_b", {txd_b, ifb.tx_ready, busy_b}, 3'b110);
    end

    // Single frame
    send(0, 8'hA5, 0);
    wait_idle(0);

    // Back-to-back with valid held high
    s0 = starts_a.size();
    send(0, 8'h00, 1);
    send(0, 8'hFF, 0);
    wait_idle(0);
    chk(starts_a.size() == s0 + 2, "b2b_frame_count", starts_a.size() - s0, 2);
    if (starts_a.size() == s0 + 2)
      chk(starts_a[s0 + 1] - starts_a[s0] == 41, "b2b_spacing", starts_a[s0 + 1] - starts_a[s0], 41);

    // Valid while busy is ignored
    s0 = starts_a.size();
    send(0, 8'hC3, 0);
    repeat (8) @(posedge clk);
    #1 set_in(0, 1'b1, 8'h3C);
    repeat (20) @(posedge clk);
    #1 set_in(0, 1'b0, 8'h00);
    wait_idle(0);
    repeat (50) @(negedge clk);
    chk(starts_a.size() == s0 + 1, "ignored_valid_frames", starts_a.size() - s0, 1);

    // Asynchronous reset during data bit 3
    send(0, 8'hA5, 0);
    repeat (16) @(posedge clk);
    #3;
    chk(txd_a == 1'b0, "pre_reset_bit3", txd_a, 0);
    rst_n = 1'b0;
    #1;
    chk({txd_a, ifa.tx_ready, busy_a} == 3'b110, "async_reset", {txd_a, ifa.tx_ready, busy_a}, 3'b110);
    expq_a.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send(0, 8'h81, 0);
    wait_idle(0);

    // One clock per bit
    send(1, 8'h5A, 0);
    wait_idle(1);

    // Randomised traffic on both transmitters
    for (int i = 0; i < 24; i++) begin
      int id;
      id = int'($urandom_range(0, 1));
      send(id, 8'($urandom), 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle(0);
    wait_idle(1);
    repeat (20) @(negedge clk);
    chk(expq_a.size() == 0 && expq_b.size() == 0, "queues_drained", expq_a.size() + expq_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1);
  end

endmodule
